alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Multi-cycle, handshaked ALU. It is the parametrised successor to the single-cycle enable-driven ALU.
- Operands enter through a valid/ready input port; results leave through a valid/ready output port with backpressure.
- Division uses an iterative restoring divider and also returns the remainder.
- Sits between the register-file/command decoder and the result/UART TX path of the system.

Parameters:
DATA_WIDTH, 8, operand width (>=2)
OUT_WIDTH, 2*DATA_WIDTH, result width; must be >= 2*DATA_WIDTH

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous active-low reset
i_IN_VALID  input  1  operand/opcode valid
o_IN_READY  output  1  block can accept a command this cycle
i_ALU_FUN  input  ALU_FUN_t (4)  opcode
i_A  input  DATA_WIDTH  operand A, unsigned
i_B  input  DATA_WIDTH  operand B, unsigned
o_OUT_VALID  output  1  result valid
i_OUT_READY  input  1  downstream accepts result
o_ALU_OUT  output  OUT_WIDTH  result
o_ZERO  output  1  o_ALU_OUT == 0
o_DIV0  output  1  result came from DIV with i_B == 0

Behaviour:
- Reset is asynchronous, active-low, on i_reset; clock is i_clk.
- Reset values: o_ALU_OUT=0, o_OUT_VALID=0, o_ZERO=0, o_DIV0=0, FSM=IDLE, divider counter=0.
- Reset mid-division aborts the division; no result is produced.
- Handshake:
  - Command accepted on a rising edge where i_IN_VALID && o_IN_READY.
  - o_IN_READY = (state==IDLE) && (!o_OUT_VALID || i_OUT_READY). This is a combinational pass-through of i_OUT_READY.
  - Result consumed on an edge where o_OUT_VALID && i_OUT_READY.
  - While o_OUT_VALID && !i_OUT_READY: o_ALU_OUT, o_ZERO and o_DIV0 hold stable.
- FSM states:
  - IDLE -> DIV: accepted DIV with i_B != 0.
  - IDLE stays IDLE: all other accepted ops.
  - DIV: DATA_WIDTH restoring steps. When the last step completes, load the result, set o_OUT_VALID and return to IDLE. The output slot is guaranteed empty at this point by the o_IN_READY rule plus the absence of other commands in flight.
- Latency:
  - Single-cycle ops and DIV-by-zero: result valid on the edge after acceptance (1 cycle).
  - DIV: valid DATA_WIDTH+1 edges after acceptance.
  - Back-to-back single-cycle ops with i_OUT_READY=1: one result per cycle.
- o_OUT_VALID clears on consumption unless a new result is loaded on the same edge; in that case it stays 1 with the new data.
- Arithmetic: operands zero-extended to OUT_WIDTH, result truncated to OUT_WIDTH.
  - ADD: A+B.
  - SUB: A-B modulo 2^OUT_WIDTH.
  - MUL: A*B.
  - DIV: quotient in bits [DATA_WIDTH-1:0], remainder in [2*DATA_WIDTH-1:DATA_WIDTH].
  - DIV with B==0: result 0, o_DIV0=1.
  - AND/OR/NAND/NOR/XOR/XNOR: bitwise on the extended operands, so inverting ops set the upper bits to 1.
  - EQU, GT: 1 or 0.
  - SHIFT_RIGHT: A>>1.
  - SHIFT_LEFT: A<<1; bit DATA_WIDTH keeps A's MSB.
  - Unused encodings (14, 15): result 0, single-cycle.
- Flags:
  - o_ZERO is computed from the loaded result and registered with it.
  - o_DIV0 is 0 for every op except DIV-by-zero.
- Inputs are ignored while o_IN_READY=0; operands are latched at acceptance.

Decomposition:
- myPkg holds ALU_FUN_t, a 4-bit enum: ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, NAND=6, NOR=7, XOR=8, XNOR=9, EQU=10, GT=11, SHIFT_RIGHT=12, SHIFT_LEFT=13.
- myPkg also holds the FSM state enum alu_mc_state_t (IDLE, DIV).
- Sub-module alu_div_seq, parametrised by DATA_WIDTH:
  - Ports: start, dividend, divisor in; busy, done, quotient, remainder out.
  - Restoring algorithm, one bit per cycle; done pulses one cycle.
- alu_mc contains the handshake, FSM, single-cycle datapath and output register.

Test Plan:
- Reset: assert i_reset=0 mid-DIV (A=200, B=7, cycle 3) -> all outputs 0; after release, o_IN_READY=1 and no stale o_OUT_VALID.
- Single-cycle stream, DATA_WIDTH=8, i_OUT_READY=1: ADD 255+1, SUB 3-5, MUL 255*255 on consecutive cycles -> outputs 0x0100, 0xFFFE, 0xFE01 on consecutive cycles; o_ZERO=0 for all.
- DIV 200/7 -> o_IN_READY low 8 cycles; o_ALU_OUT=0x041C (rem 4, quot 28) exactly 9 edges after acceptance; o_DIV0=0.
- DIV 13/0 -> o_ALU_OUT=0, o_ZERO=1, o_DIV0=1, valid after 1 edge, no DIV state entered.
- Backpressure: XOR 0xF0^0x0F with i_OUT_READY=0 for 5 cycles -> o_ALU_OUT=0x00FF held stable, o_IN_READY=0; on release, consumed and next command accepted same edge.
- Flags and edges: NAND 0xFF&0xFF -> 0xFF00, o_ZERO=0; SHIFT_LEFT 0x80 -> 0x0100; EQU 5,5 -> 1; opcode 15 -> 0 with o_ZERO=1.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding and control FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package myPkg;

    // Opcode encoding. Values 14 and 15 are unused and produce a zero result.
    typedef enum logic [3:0] {
        ADD         = 4'd0,
        SUB         = 4'd1,
        MUL         = 4'd2,
        DIV         = 4'd3,
        AND         = 4'd4,
        OR          = 4'd5,
        NAND        = 4'd6,
        NOR         = 4'd7,
        XOR         = 4'd8,
        XNOR        = 4'd9,
        EQU         = 4'd10,
        GT          = 4'd11,
        SHIFT_RIGHT = 4'd12,
        SHIFT_LEFT  = 4'd13
    } ALU_FUN_t;

    // The control FSM is either free, or waiting on the iterative divider.
    // The states carry an S_ prefix so they do not collide with the DIV opcode.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } alu_mc_state_t;

endpackage

// File: rtl/alu_mc_div_seq.sv
// Restoring unsigned divider, one quotient bit per clock.
// Latency: done pulses DATA_WIDTH cycles after the start cycle; results hold until the next start.
// Backpressure: none; start is ignored while busy, so the caller must not issue a start mid-division.
//
// Ports: start_i/dividend_i/divisor_i load a new division; busy_o is high while
// steps remain; done_o is a one-cycle pulse once quotient_o/remainder_o are final.
module alu_div_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    // Holds the not-yet-consumed dividend bits in the top and the quotient
    // bits shifted in at the bottom; after DATA_WIDTH steps it is the quotient.
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   trial;

    assign busy_o      = (cnt_q != '0);
    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

    always_comb begin
        // Partial remainder stays below the divisor, so the shifted value fits
        // DATA_WIDTH+1 bits and a non-negative trial fits back into DATA_WIDTH.
        shifted = {rem_q, quo_q[DATA_WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};

        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;

        if (busy_o) begin
            if (!trial[DATA_WIDTH]) begin
                rem_d = trial[DATA_WIDTH-1:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[DATA_WIDTH-1:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
            end
            cnt_d  = cnt_q - 1'b1;
            done_d = (cnt_q == CW'(1));
        end else if (start_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
            cnt_d = CW'(DATA_WIDTH);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle ops plus an iterative divider returning {remainder, quotient}.
// Latency: 1 edge for single-cycle ops and divide-by-zero; DATA_WIDTH+1 edges for a real division.
// Backpressure: result register holds while o_OUT_VALID && !i_OUT_READY; o_IN_READY drops until it drains.
//
// Ports: i_IN_VALID/o_IN_READY + i_ALU_FUN/i_A/i_B form the command port;
// o_OUT_VALID/i_OUT_READY + o_ALU_OUT/o_ZERO/o_DIV0 form the result port.
module alu_mc
    import myPkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_IN_VALID,
    output logic                  o_IN_READY,
    input  ALU_FUN_t              i_ALU_FUN,
    input  logic [DATA_WIDTH-1:0] i_A,
    input  logic [DATA_WIDTH-1:0] i_B,
    output logic                  o_OUT_VALID,
    input  logic                  i_OUT_READY,
    output logic [OUT_WIDTH-1:0]  o_ALU_OUT,
    output logic                  o_ZERO,
    output logic                  o_DIV0
);

    if (DATA_WIDTH < 2) begin : g_bad_data_width
        $error("alu_mc: DATA_WIDTH must be >= 2");
    end
    if (OUT_WIDTH < 2 * DATA_WIDTH) begin : g_bad_out_width
        $error("alu_mc: OUT_WIDTH must be >= 2*DATA_WIDTH");
    end

    alu_mc_state_t         state_q, state_d;
    logic [OUT_WIDTH-1:0]  alu_out_q, alu_out_d;
    logic                  out_vld_q, out_vld_d;
    logic                  zero_q, zero_d;
    logic                  div0_q, div0_d;

    logic [OUT_WIDTH-1:0]  a_ext, b_ext;
    logic [OUT_WIDTH-1:0]  comb_res;
    logic                  comb_div0;
    logic [OUT_WIDTH-1:0]  div_res;
    logic                  accept;
    logic                  is_div_nz;
    logic                  div_start;
    logic                  div_busy;
    logic                  div_done;
    logic [DATA_WIDTH-1:0] div_quo, div_rem;

    // Slot is free when empty or being drained on this same edge.
    assign o_IN_READY  = (state_q == S_IDLE) && (!out_vld_q || i_OUT_READY);
    assign accept      = i_IN_VALID && o_IN_READY;
    assign is_div_nz   = (i_ALU_FUN == DIV) && (i_B != '0);

    assign o_OUT_VALID = out_vld_q;
    assign o_ALU_OUT   = alu_out_q;
    assign o_ZERO      = zero_q;
    assign o_DIV0      = div0_q;

    alu_div_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .start_i     (div_start),
        .dividend_i  (i_A),
        .divisor_i   (i_B),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    // Single-cycle datapath on zero-extended operands, so the inverting
    // bitwise ops fill the upper bits with ones.
    always_comb begin
        a_ext     = OUT_WIDTH'(i_A);
        b_ext     = OUT_WIDTH'(i_B);
        comb_res  = '0;
        comb_div0 = 1'b0;
        case (i_ALU_FUN)
            ADD:         comb_res = a_ext + b_ext;
            SUB:         comb_res = a_ext - b_ext;
            MUL:         comb_res = a_ext * b_ext;
            DIV:         comb_div0 = 1'b1;  // only reaches here when i_B == 0
            AND:         comb_res = a_ext & b_ext;
            OR:          comb_res = a_ext | b_ext;
            NAND:        comb_res = ~(a_ext & b_ext);
            NOR:         comb_res = ~(a_ext | b_ext);
            XOR:         comb_res = a_ext ^ b_ext;
            XNOR:        comb_res = ~(a_ext ^ b_ext);
            EQU:         comb_res = OUT_WIDTH'(i_A == i_B);
            GT:          comb_res = OUT_WIDTH'(i_A > i_B);
            SHIFT_RIGHT: comb_res = a_ext >> 1;
            SHIFT_LEFT:  comb_res = a_ext << 1;
            default:     comb_res = '0;
        endcase
    end

    always_comb begin
        div_res                              = '0;
        div_res[DATA_WIDTH-1:0]              = div_quo;
        div_res[2*DATA_WIDTH-1:DATA_WIDTH]   = div_rem;
    end

    // Control FSM and output-register next state.
    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        zero_d    = zero_q;
        div0_d    = div0_q;
        out_vld_d = out_vld_q && !i_OUT_READY;
        div_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_div_nz) begin
                        div_start = !div_busy;
                        state_d   = S_DIV;
                    end else begin
                        alu_out_d = comb_res;
                        zero_d    = (comb_res == '0);
                        div0_d    = comb_div0;
                        out_vld_d = 1'b1;
                    end
                end
            end
            S_DIV: begin
                // o_IN_READY kept the slot drained, so loading here never
                // overwrites an unconsumed result.
                if (div_done) begin
                    alu_out_d = div_res;
                    zero_d    = (div_res == '0);
                    div0_d    = 1'b0;
                    out_vld_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            alu_out_q <= '0;
            out_vld_q <= 1'b0;
            zero_q    <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            out_vld_q <= out_vld_d;
            zero_q    <= zero_d;
            div0_q    <= div0_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc with hand-computed expected values, DATA_WIDTH=8.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_mc;
    import myPkg::*;

    localparam int DW = 8;
    localparam int OW = 16;

    logic          i_clk;
    logic          i_reset;
    logic          in_vld;
    logic          in_rdy;
    ALU_FUN_t      fun;
    logic [DW-1:0] a, b;
    logic          out_vld;
    logic          out_rdy;
    logic [OW-1:0] alu_out;
    logic          zero;
    logic          div0;

    int tests_run = 0;
    int tests_failed = 0;

    alu_mc #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_IN_VALID  (in_vld),
        .o_IN_READY  (in_rdy),
        .i_ALU_FUN   (fun),
        .i_A         (a),
        .i_B         (b),
        .o_OUT_VALID (out_vld),
        .i_OUT_READY (out_rdy),
        .o_ALU_OUT   (alu_out),
        .o_ZERO      (zero),
        .o_DIV0      (div0)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input ALU_FUN_t op, input logic [DW-1:0] av, input logic [DW-1:0] bv);
        fun    = op;
        a      = av;
        b      = bv;
        in_vld = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int held;
        int seen_vld;

        i_reset = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        fun     = ADD;
        a       = '0;
        b       = '0;

        // Reset state
        #12;
        chk("rst_out",   32'(alu_out), 32'h0);
        chk("rst_vld",   32'(out_vld), 32'h0);
        chk("rst_zero",  32'(zero),    32'h0);
        chk("rst_div0",  32'(div0),    32'h0);
        chk("rst_inrdy", 32'(in_rdy),  32'h1);
        tick();
        i_reset = 1'b1;
        tick();

        // Reset during a division aborts it
        drive(DIV, 8'd200, 8'd7);
        tick();
        in_vld = 1'b0;
        tick(); tick(); tick();
        #2 i_reset = 1'b0;
        #1;
        chk("midrst_out",  32'(alu_out), 32'h0);
        chk("midrst_vld",  32'(out_vld), 32'h0);
        chk("midrst_zero", 32'(zero),    32'h0);
        chk("midrst_div0", 32'(div0),    32'h0);
        tick();
        i_reset = 1'b1;
        chk("midrst_inrdy", 32'(in_rdy), 32'h1);
        seen_vld = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_vld) seen_vld++;
        end
        chk("midrst_stale_vld", 32'(seen_vld), 32'h0);

        // Back-to-back single-cycle stream
        drive(ADD, 8'd255, 8'd1);
        tick();
        chk("add_out",  32'(alu_out), 32'h0100);
        chk("add_vld",  32'(out_vld), 32'h1);
        chk("add_zero", 32'(zero),    32'h0);
        drive(SUB, 8'd3, 8'd5);
        tick();
        chk("sub_out",  32'(alu_out), 32'hFFFE);
        chk("sub_vld",  32'(out_vld), 32'h1);
        chk("sub_zero", 32'(zero),    32'h0);
        drive(MUL, 8'd255, 8'd255);
        tick();
        chk("mul_out",  32'(alu_out), 32'hFE01);
        chk("mul_vld",  32'(out_vld), 32'h1);
        chk("mul_zero", 32'(zero),    32'h0);
        in_vld = 1'b0;
        tick();
        chk("stream_drained", 32'(out_vld), 32'h0);

        // DIV 200/7 -> rem 4, quot 28
        drive(DIV, 8'd200, 8'd7);
        tick();
        in_vld = 1'b0;
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!in_rdy && !out_vld) lows++;
        end
        chk("div_busy_cycles", 32'(lows), 32'd8);
        tick();
        chk("div_vld",   32'(out_vld), 32'h1);
        chk("div_out",   32'(alu_out), 32'h041C);
        chk("div_div0",  32'(div0),    32'h0);
        chk("div_zero",  32'(zero),    32'h0);
        chk("div_inrdy", 32'(in_rdy),  32'h1);
        tick();
        chk("div_drained", 32'(out_vld), 32'h0);

        // DIV by zero is single-cycle
        drive(DIV, 8'd13, 8'd0);
        tick();
        in_vld = 1'b0;
        chk("div0_vld",   32'(out_vld), 32'h1);
        chk("div0_out",   32'(alu_out), 32'h0);
        chk("div0_zero",  32'(zero),    32'h1);
        chk("div0_flag",  32'(div0),    32'h1);
        chk("div0_idle",  32'(in_rdy),  32'h1);
        tick();
        chk("div0_drained", 32'(out_vld), 32'h0);

        // Backpressure: result holds, new command offered but ignored
        out_rdy = 1'b0;
        drive(XOR, 8'hF0, 8'h0F);
        tick();
        drive(NAND, 8'hFF, 8'hFF);
        held = 0;
        for (int i = 0; i < 5; i++) begin
            if (alu_out == 16'h00FF && out_vld && !in_rdy && !zero && !div0) held++;
            tick();
        end
        chk("bp_held_cycles", 32'(held), 32'd5);
        chk("bp_out", 32'(alu_out), 32'h00FF);
        out_rdy = 1'b1;
        #1;
        chk("bp_release_inrdy", 32'(in_rdy), 32'h1);
        tick();
        chk("nand_out",  32'(alu_out), 32'hFF00);
        chk("nand_vld",  32'(out_vld), 32'h1);
        chk("nand_zero", 32'(zero),    32'h0);

        // Edge cases
        drive(SHIFT_LEFT, 8'h80, 8'h00);
        tick();
        chk("shl_out", 32'(alu_out), 32'h0100);
        drive(EQU, 8'd5, 8'd5);
        tick();
        chk("equ_out",  32'(alu_out), 32'h0001);
        chk("equ_zero", 32'(zero),    32'h0);
        drive(GT, 8'd3, 8'd9);
        tick();
        chk("gt_out",  32'(alu_out), 32'h0000);
        chk("gt_zero", 32'(zero),    32'h1);
        drive(SHIFT_RIGHT, 8'h81, 8'h00);
        tick();
        chk("shr_out", 32'(alu_out), 32'h0040);
        drive(ALU_FUN_t'(4'd15), 8'hAA, 8'h55);
        tick();
        chk("op15_out",  32'(alu_out), 32'h0000);
        chk("op15_zero", 32'(zero),    32'h1);
        chk("op15_div0", 32'(div0),    32'h0);
        in_vld = 1'b0;
        tick();
        chk("final_drained", 32'(out_vld), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
